udp_send_mc: RTL and testbench
==============================

Name: udp_send_mc

Overview:
Multi-channel, parametrised UDP/IPv4/Ethernet encapsulator for the SFP 1G transmit path.
- CH_NUM byte-stream sources each present a 14-byte descriptor followed by payload.
- A round-robin arbiter selects one source per frame. The block prepends a 42-byte Eth/IP/UDP header with a computed IP checksum and an incrementing IP identification, then streams the payload to the MAC under valid/ready backpressure.
- Oversized frames are dropped and counted.

Parameters:
CH_NUM, 4, number of input channels (1..8)
TTL, 8'h80, IP time-to-live
MAX_PAYLOAD, 1472, largest accepted payload length L in bytes; larger frames are dropped
ID_INIT, 16'h0000, IP identification value after reset

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
local_ip  in  32  source IP
local_mac  in  48  source MAC
local_port  in  CH_NUM*16  source UDP port per channel; channel i uses [16i+15:16i]
rx_data  in  CH_NUM*8  byte per channel
rx_valid  in  CH_NUM  byte valid per channel
rx_ready  out  CH_NUM  byte accepted per channel; one-hot or zero
tx_data  out  8  output byte
tx_valid  out  1  output byte valid
tx_sof  out  1  high with first header byte
tx_eof  out  1  high with last frame byte
tx_ready  in  1  sink accepts byte when tx_valid&tx_ready
frame_cnt  out  32  frames transmitted, wraps
drop_cnt  out  16  frames dropped, saturates at FFFF

Behaviour:
- Reset: all outputs 0; frame_cnt=0; drop_cnt=0; IP ID=ID_INIT; RR pointer=0; state IDLE.
- Input framing per channel, big-endian:
  - L[15:0] (payload bytes)
  - dest_mac (6 bytes)
  - dest_ip (4 bytes)
  - dest_port (2 bytes)
  - then exactly L payload bytes.
  - A byte transfers on rx_valid[i]&rx_ready[i].
- FSM:
  - IDLE: any rx_valid -> ARB.
  - ARB (1 cycle): grant the first requesting channel searching upward from RR pointer+1 modulo CH_NUM; RR pointer := granted channel.
  - DESC: rx_ready[g]=rx_valid[g]; capture 14 bytes. After the 14th byte: L>MAX_PAYLOAD -> DROP, else CALC.
  - CALC: exactly 8 cycles of one's-complement sum with end-around carry over 4500, L+28, ID, 0000, {TTL,11}, src IP hi/lo, dst IP hi/lo; fold; invert. Then -> HEAD.
  - HEAD: emit 42 header bytes, each held until tx_ready:
    - dest_mac, local_mac, 0800
    - 45 00, L+28, ID, 00 00, TTL, 11, checksum, local_ip, dest_ip
    - src port, dest port, L+8, 00 00 (UDP checksum 0)
    - After the last header byte: L==0 -> DONE, else PAYLOAD.
  - PAYLOAD: combinational pass-through: tx_data=rx_data[g], tx_valid=rx_valid[g], rx_ready[g]=tx_ready. Count L bytes; tx_eof on byte L -> DONE.
  - L==0: tx_eof on header byte 42.
  - DROP: rx_ready[g]=1; consume L bytes with tx_valid=0; drop_cnt++ -> IDLE.
  - DONE (1 cycle): frame_cnt++; ID++ (wraps FFFF->0000) -> IDLE.
- tx_data/tx_sof/tx_eof stable while tx_valid&!tx_ready.
- The granted channel is not pre-empted; other channels wait.
- rx_valid low mid-frame stalls the output (tx_valid=0); no timeout.
- rst_n low at any point aborts the frame immediately. Counters and ID reset; a partially sent frame is not terminated with tx_eof.
- Arithmetic: L+28 and L+8 are modulo 2^16 (L is bounded by MAX_PAYLOAD).
- Minimum gap from descriptor end to first header byte: 9 cycles.

Optional Feature:
VLAN_EN: when defined, insert an 802.1Q tag after local_mac: 81 00 then vlan_tci[15:0].
- Header becomes 46 bytes.
- Adds input port vlan_tci (16 bits).
- IP/UDP lengths and checksum are unchanged.

Without VLAN_EN: no vlan_tci port; 42-byte header.

Test Plan:
1. Ch0, L=18, dst C0A80114, local_ip C0A8010A, ID=0, TTL=80:
   - header bytes 16-17 = 002E; bytes 24-25 = B750; bytes 38-39 = 001A
   - 60 bytes total; tx_eof on byte 60; frame_cnt=1
2. Two back-to-back frames on the same channel -> second frame carries ID 0001 and checksum B74F.
3. All 4 channels requesting continuously -> grant order 1,2,3,0,1; no channel granted twice before the others.
4. L=MAX_PAYLOAD+1 on ch2 -> 1487 bytes consumed, tx_valid never asserted, drop_cnt=1; the next frame is sent normally.
5. L=0 -> 42-byte frame; tx_sof and tx_eof on bytes 1 and 42. Random tx_ready throttling (50%) -> byte sequence identical to the unthrottled run.
6. rst_n asserted at payload byte 5 -> outputs 0 asynchronously; after release, a new frame starts with ID_INIT and a correct checksum.

Source files
------------

// File: rtl/udp_send_mc_if.sv
// +----------------------------------------------------------------------+
// | udp_send_mc_if                                                       |
// | Byte-stream bundle for udp_send_mc: per-channel source bytes in,     |
// | framed Ethernet byte stream out, both with valid/ready handshakes.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface udp_send_mc_if #(
    parameter int CH_NUM = 4
) ();
    logic [CH_NUM*8-1:0] rx_data;
    logic [CH_NUM-1:0]   rx_valid;
    logic [CH_NUM-1:0]   rx_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_sof;
    logic                tx_eof;
    logic                tx_ready;

    // Encapsulator side: accepts source bytes, drives the MAC stream
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        output tx_sof,
        output tx_eof,
        input  tx_ready
    );

    // Environment side: sources and MAC sink
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        input  tx_sof,
        input  tx_eof,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/udp_send_mc.sv
// +----------------------------------------------------------------------+
// | udp_send_mc                                                          |
// | Multi-channel UDP/IPv4/Ethernet encapsulator. Round-robin selects a  |
// | source per frame, reads its 14-byte descriptor, computes the IP      |
// | header checksum, emits a 42-byte header then passes payload through. |
// | Oversized frames are consumed silently and counted.                  |
// | Optional: define VLAN_EN to insert an 802.1Q tag (46-byte header,    |
// | extra vlan_tci input).                                               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module udp_send_mc #(
    parameter int          CH_NUM      = 4,
    parameter logic [7:0]  TTL         = 8'h80,
    parameter int          MAX_PAYLOAD = 1472,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [31:0]          local_ip,
    input  wire logic [47:0]          local_mac,
    input  wire logic [CH_NUM*16-1:0] local_port,
`ifdef VLAN_EN
    input  wire logic [15:0]          vlan_tci,
`endif
    udp_send_mc_if.master             bus,
    output logic [31:0]               frame_cnt,
    output logic [15:0]               drop_cnt
);

    localparam int GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
`ifdef VLAN_EN
    localparam int HDR_LEN = 46;
`else
    localparam int HDR_LEN = 42;
`endif
    localparam logic [5:0]  HDR_LAST = 6'(HDR_LEN - 1);
    localparam logic [15:0] MAX_L    = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_DESC    = 3'd2,
        S_CALC    = 3'd3,
        S_HEAD    = 3'd4,
        S_PAYLOAD = 3'd5,
        S_DROP    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_grant;
    logic [111:0]  r_desc;
    logic [3:0]    r_dcnt;
    logic [15:0]   r_sum;
    logic [2:0]    r_ccnt;
    logic [5:0]    r_hidx;
    logic [15:0]   r_pcnt;
    logic [15:0]   r_id;
    logic [31:0]   r_frame_cnt;
    logic [15:0]   r_drop_cnt;

    logic          w_found;
    logic [GW-1:0] w_pick;
    logic [15:0]   w_term;
    logic [16:0]   w_add;
    logic [15:0]   w_sum_next;
    logic [5:0]    w_bidx;
    logic [7:0]    w_hbyte;
    logic [CH_NUM-1:0] w_rx_ready;
    logic [7:0]    w_tx_data;
    logic          w_tx_valid;
    logic          w_tx_sof;
    logic          w_tx_eof;

    // Descriptor fields once all 14 bytes are shifted in
    wire logic [15:0] w_len      = r_desc[111:96];
    wire logic [47:0] w_dmac     = r_desc[95:48];
    wire logic [31:0] w_dip      = r_desc[47:16];
    wire logic [15:0] w_dport    = r_desc[15:0];
    // Length as seen while the 14th descriptor byte is on the bus
    wire logic [15:0] w_len_desc = r_desc[103:88];
    wire logic [15:0] w_len_ip   = w_len + 16'd28;
    wire logic [15:0] w_len_udp  = w_len + 16'd8;
    wire logic [15:0] w_csum     = ~r_sum;
    wire logic [15:0] w_sport    = local_port[{r_grant, 4'b0000} +: 16];
    wire logic [7:0]  w_rx_byte  = bus.rx_data[{r_grant, 3'b000} +: 8];
    wire logic        w_rx_vld   = bus.rx_valid[r_grant];
    wire logic        w_pay_last = (r_pcnt == w_len - 16'd1);

    // Round-robin search: first requester strictly after the last grant
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            if (!w_found && bus.rx_valid[(int'(r_ptr) + k) % CH_NUM]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_ptr) + k) % CH_NUM);
            end
        end
    end

    // Checksum term for the current CALC cycle (the zero fragment term is a no-op)
    always_comb begin
        w_term = 16'h0000;
        case (r_ccnt)
            3'd0:    w_term = 16'h4500;
            3'd1:    w_term = w_len_ip;
            3'd2:    w_term = r_id;
            3'd3:    w_term = {TTL, 8'h11};
            3'd4:    w_term = local_ip[31:16];
            3'd5:    w_term = local_ip[15:0];
            3'd6:    w_term = w_dip[31:16];
            default: w_term = w_dip[15:0];
        endcase
        w_add      = {1'b0, r_sum} + {1'b0, w_term};
        w_sum_next = w_add[15:0] + {15'd0, w_add[16]};
    end

    // Header byte selection by position
    always_comb begin
        w_hbyte = 8'h00;
        w_bidx  = r_hidx;
`ifdef VLAN_EN
        if (r_hidx >= 6'd16) begin
            w_bidx = r_hidx - 6'd4;
        end
`endif
        case (w_bidx)
            6'd0:  w_hbyte = w_dmac[47:40];
            6'd1:  w_hbyte = w_dmac[39:32];
            6'd2:  w_hbyte = w_dmac[31:24];
            6'd3:  w_hbyte = w_dmac[23:16];
            6'd4:  w_hbyte = w_dmac[15:8];
            6'd5:  w_hbyte = w_dmac[7:0];
            6'd6:  w_hbyte = local_mac[47:40];
            6'd7:  w_hbyte = local_mac[39:32];
            6'd8:  w_hbyte = local_mac[31:24];
            6'd9:  w_hbyte = local_mac[23:16];
            6'd10: w_hbyte = local_mac[15:8];
            6'd11: w_hbyte = local_mac[7:0];
            6'd12: w_hbyte = 8'h08;
            6'd13: w_hbyte = 8'h00;
            6'd14: w_hbyte = 8'h45;
            6'd15: w_hbyte = 8'h00;
            6'd16: w_hbyte = w_len_ip[15:8];
            6'd17: w_hbyte = w_len_ip[7:0];
            6'd18: w_hbyte = r_id[15:8];
            6'd19: w_hbyte = r_id[7:0];
            6'd22: w_hbyte = TTL;
            6'd23: w_hbyte = 8'h11;
            6'd24: w_hbyte = w_csum[15:8];
            6'd25: w_hbyte = w_csum[7:0];
            6'd26: w_hbyte = local_ip[31:24];
            6'd27: w_hbyte = local_ip[23:16];
            6'd28: w_hbyte = local_ip[15:8];
            6'd29: w_hbyte = local_ip[7:0];
            6'd30: w_hbyte = w_dip[31:24];
            6'd31: w_hbyte = w_dip[23:16];
            6'd32: w_hbyte = w_dip[15:8];
            6'd33: w_hbyte = w_dip[7:0];
            6'd34: w_hbyte = w_sport[15:8];
            6'd35: w_hbyte = w_sport[7:0];
            6'd36: w_hbyte = w_dport[15:8];
            6'd37: w_hbyte = w_dport[7:0];
            6'd38: w_hbyte = w_len_udp[15:8];
            6'd39: w_hbyte = w_len_udp[7:0];
            default: w_hbyte = 8'h00;
        endcase
`ifdef VLAN_EN
        // 802.1Q tag sits between the source MAC and the EtherType
        if (r_hidx >= 6'd12 && r_hidx < 6'd16) begin
            case (r_hidx[1:0])
                2'd0:    w_hbyte = 8'h81;
                2'd1:    w_hbyte = 8'h00;
                2'd2:    w_hbyte = vlan_tci[15:8];
                default: w_hbyte = vlan_tci[7:0];
            endcase
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake/stream outputs
    always_comb begin
        w_next     = r_state;
        w_rx_ready = '0;
        w_tx_data  = 8'h00;
        w_tx_valid = 1'b0;
        w_tx_sof   = 1'b0;
        w_tx_eof   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.rx_valid) begin
                    w_next = S_ARB;
                end
            end
            S_ARB: begin
                w_next = w_found ? S_DESC : S_IDLE;
            end
            S_DESC: begin
                w_rx_ready[r_grant] = w_rx_vld;
                if (w_rx_vld && r_dcnt == 4'd13) begin
                    w_next = (w_len_desc > MAX_L) ? S_DROP : S_CALC;
                end
            end
            S_CALC: begin
                if (r_ccnt == 3'd7) begin
                    w_next = S_HEAD;
                end
            end
            S_HEAD: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_hbyte;
                w_tx_sof   = (r_hidx == 6'd0);
                w_tx_eof   = (r_hidx == HDR_LAST) && (w_len == 16'd0);
                if (bus.tx_ready && r_hidx == HDR_LAST) begin
                    w_next = (w_len == 16'd0) ? S_DONE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Payload is a straight combinational pass-through
                w_tx_valid          = w_rx_vld;
                w_tx_data           = w_rx_byte;
                w_tx_eof            = w_rx_vld && w_pay_last;
                w_rx_ready[r_grant] = bus.tx_ready;
                if (w_rx_vld && bus.tx_ready && w_pay_last) begin
                    w_next = S_DONE;
                end
            end
            S_DROP: begin
                w_rx_ready[r_grant] = 1'b1;
                if (w_rx_vld && w_pay_last) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: arbitration, descriptor capture, checksum, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_desc      <= '0;
            r_dcnt      <= '0;
            r_sum       <= '0;
            r_ccnt      <= '0;
            r_hidx      <= '0;
            r_pcnt      <= '0;
            r_id        <= ID_INIT;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dcnt <= '0;
                    r_ccnt <= '0;
                    r_hidx <= '0;
                    r_pcnt <= '0;
                    r_sum  <= '0;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_pick;
                    end
                end
                S_DESC: begin
                    if (w_rx_vld) begin
                        r_desc <= {r_desc[103:0], w_rx_byte};
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                end
                S_CALC: begin
                    r_sum  <= w_sum_next;
                    r_ccnt <= r_ccnt + 3'd1;
                end
                S_HEAD: begin
                    if (bus.tx_ready) begin
                        r_hidx <= r_hidx + 6'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (w_rx_vld && bus.tx_ready) begin
                        r_pcnt <= r_pcnt + 16'd1;
                    end
                end
                S_DROP: begin
                    if (w_rx_vld) begin
                        r_pcnt <= r_pcnt + 16'd1;
                        if (w_pay_last && r_drop_cnt != 16'hFFFF) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                    r_id        <= r_id + 16'd1;
                end
                default: begin
                    r_dcnt <= '0;
                end
            endcase
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.tx_data  = w_tx_data;
    assign bus.tx_valid = w_tx_valid;
    assign bus.tx_sof   = w_tx_sof;
    assign bus.tx_eof   = w_tx_eof;
    assign frame_cnt    = r_frame_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_udp_send_mc.sv
// +----------------------------------------------------------------------+
// | tb_udp_send_mc                                                       |
// | Self-checking bench for udp_send_mc: table of frames with known IP   |
// | checksums, plus arbitration, drop, throttling and reset sequences.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_udp_send_mc;

    localparam int          CH    = 4;
    localparam logic [7:0]  TTL   = 8'h80;
    localparam int          MAXP  = 1472;
    localparam logic [15:0] IDI   = 16'h0000;
    localparam logic [31:0] LIP   = 32'hC0A8010A;
    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [63:0] LPORT = 64'h1003_1002_1001_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
`ifdef VLAN_EN
    localparam logic [15:0] VTCI = 16'h6123;
`endif

    udp_send_mc_if #(.CH_NUM(CH)) bus ();

    udp_send_mc #(
        .CH_NUM      (CH),
        .TTL         (TTL),
        .MAX_PAYLOAD (MAXP),
        .ID_INIT     (IDI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .local_ip   (LIP),
        .local_mac  (LMAC),
        .local_port (LPORT),
`ifdef VLAN_EN
        .vlan_tci   (VTCI),
`endif
        .bus        (bus),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_t;

    typedef struct {
        int          ch;
        int          len;
        logic [31:0] dip;
        logic [15:0] csum;
        bit          wait_after;
        int          frames_after;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  src_q[CH][$];
    int          checks = 0;
    int          errors = 0;
    int          nbytes = 0;
    bit          throttle = 1'b0;
    bit          in_drop = 1'b0;
    logic [CH-1:0] xfer_s = '0;
    logic [15:0] tb_id = IDI;
    int          tb_frames = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  pd;
    logic        ps, pe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_csum(input logic [15:0] len, input logic [15:0] id,
                                               input logic [31:0] dip);
        logic [31:0] s;
        logic [15:0] l28;
        l28 = len + 16'd28;
        s = 32'h4500 + {16'd0, l28} + {16'd0, id} + {16'd0, TTL, 8'h11}
          + {16'd0, LIP[31:16]} + {16'd0, LIP[15:0]} + {16'd0, dip[31:16]} + {16'd0, dip[15:0]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0);
        for (int c = 0; c < CH; c++) if (src_q[c].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic push16(input logic [15:0] v, inout logic [7:0] q[$]);
        q.push_back(v[15:8]);
        q.push_back(v[7:0]);
    endtask

    // Queue source bytes for one frame and, unless dropped, its expected output
    task automatic send_frame(input int ch, input int len, input logic [31:0] dip,
                              input logic [15:0] csum_in, input bit use_csum, input bit drop);
        logic [47:0] dmac;
        logic [15:0] dport;
        logic [15:0] l;
        logic [15:0] cs;
        logic [7:0]  hdr[$];
        logic [7:0]  pay;
        exp_t        e;
        dmac  = {40'h0A0B0C0D0E, 8'(ch)};
        dport = 16'h2345;
        l     = 16'(len);
        cs    = use_csum ? csum_in : model_csum(l, tb_id, dip);
        push16(l, src_q[ch]);
        for (int i = 5; i >= 0; i--) src_q[ch].push_back(dmac[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) src_q[ch].push_back(dip[i*8 +: 8]);
        push16(dport, src_q[ch]);
        for (int i = 5; i >= 0; i--) hdr.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) hdr.push_back(LMAC[i*8 +: 8]);
`ifdef VLAN_EN
        push16(16'h8100, hdr);
        push16(VTCI, hdr);
`endif
        push16(16'h0800, hdr);
        push16(16'h4500, hdr);
        push16(l + 16'd28, hdr);
        push16(tb_id, hdr);
        push16(16'h0000, hdr);
        hdr.push_back(TTL);
        hdr.push_back(8'h11);
        push16(cs, hdr);
        for (int i = 3; i >= 0; i--) hdr.push_back(LIP[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) hdr.push_back(dip[i*8 +: 8]);
        push16(LPORT[ch*16 +: 16], hdr);
        push16(dport, hdr);
        push16(l + 16'd8, hdr);
        push16(16'h0000, hdr);
        if (!drop) begin
            for (int i = 0; i < hdr.size(); i++) begin
                e.d = hdr[i]; e.sof = (i == 0); e.eof = (len == 0) && (i == hdr.size() - 1);
                exp_q.push_back(e);
            end
        end
        for (int p = 0; p < len; p++) begin
            pay = 8'($urandom);
            src_q[ch].push_back(pay);
            if (!drop) begin
                e.d = pay; e.sof = 1'b0; e.eof = (p == len - 1);
                exp_q.push_back(e);
            end
        end
        if (!drop) begin
            tb_id++;
            tb_frames++;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (n < budget && !all_empty()) begin
            @(posedge clk);
            n++;
        end
        if (!all_empty()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        for (int c = 0; c < CH; c++) src_q[c].delete();
        tb_id = IDI;
        tb_frames = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Source and sink driver: advance queues on accepted bytes, present next
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            if (xfer_s[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            bus.rx_valid[c]       = (src_q[c].size() > 0);
            bus.rx_data[c*8 +: 8] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
        end
        xfer_s = '0;
        bus.tx_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard compare, hold-stability and drop-silence checks
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            xfer_s = bus.rx_valid & bus.rx_ready;
            if (prev_stall) begin
                checks++;
                if (!(bus.tx_valid && bus.tx_data == pd && bus.tx_sof == ps && bus.tx_eof == pe)) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0h expected v=1 d=%0h", bus.tx_valid, bus.tx_data, pd);
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            pd = bus.tx_data; ps = bus.tx_sof; pe = bus.tx_eof;
            if (in_drop) begin
                checks++;
                if (bus.tx_valid) begin
                    errors++;
                    $display("FAIL drop_silent: got tx_valid=1 expected 0");
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                nbytes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.tx_data !== e.d || bus.tx_sof !== e.sof || bus.tx_eof !== e.eof) begin
                        errors++;
                        $display("FAIL byte: got d=%0h sof=%0b eof=%0b expected d=%0h sof=%0b eof=%0b",
                                 bus.tx_data, bus.tx_sof, bus.tx_eof, e.d, e.sof, e.eof);
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
            xfer_s = '0;
        end
    end

    vec_t vecs[4];

    initial begin
        int n;
        int target;
        vecs[0] = '{ch: 0, len: 18, dip: 32'hC0A80114, csum: 16'hB750, wait_after: 1'b1, frames_after: 1};
        vecs[1] = '{ch: 0, len: 18, dip: 32'hC0A80114, csum: 16'hB74F, wait_after: 1'b0, frames_after: 0};
        vecs[2] = '{ch: 0, len: 0,  dip: 32'hC0A80114, csum: 16'hB760, wait_after: 1'b1, frames_after: 3};
        vecs[3] = '{ch: 3, len: 5,  dip: 32'h0A000001, csum: 16'h6F16, wait_after: 1'b1, frames_after: 4};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_sof", 64'(bus.tx_sof), 64'd0);
        chk("rst_tx_eof", 64'(bus.tx_eof), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Table of frames with hand-computed checksums
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].ch, vecs[v].len, vecs[v].dip, vecs[v].csum, 1'b1, 1'b0);
            if (vecs[v].wait_after) begin
                wait_idle(2000, "table");
                chk("table_frame_cnt", 64'(frame_cnt), 64'(vecs[v].frames_after));
            end
        end

        // Round-robin with all channels requesting; expected order 1,2,3,0,1
        pulse_reset();
        chk("rr_reset_frame_cnt", 64'(frame_cnt), 64'd0);
        send_frame(1, 3, 32'hC0A80101, 16'h0, 1'b0, 1'b0);
        send_frame(2, 4, 32'hC0A80102, 16'h0, 1'b0, 1'b0);
        send_frame(3, 5, 32'hC0A80103, 16'h0, 1'b0, 1'b0);
        send_frame(0, 6, 32'hC0A80104, 16'h0, 1'b0, 1'b0);
        send_frame(1, 7, 32'hC0A80105, 16'h0, 1'b0, 1'b0);
        wait_idle(3000, "rr");
        chk("rr_frame_cnt", 64'(frame_cnt), 64'd5);

        // Oversized frame dropped, next one sent normally
        in_drop = 1'b1;
        send_frame(2, MAXP + 1, 32'hC0A80106, 16'h0, 1'b0, 1'b1);
        wait_idle(4000, "drop");
        in_drop = 1'b0;
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
        chk("drop_frame_cnt", 64'(frame_cnt), 64'd5);
        send_frame(2, 10, 32'hC0A80107, 16'h0, 1'b0, 1'b0);
        wait_idle(2000, "after_drop");
        chk("after_drop_frame_cnt", 64'(frame_cnt), 64'd6);

        // Zero-length frames, unthrottled then with random backpressure
        send_frame(1, 0, 32'hC0A80108, 16'h0, 1'b0, 1'b0);
        wait_idle(2000, "zero");
        throttle = 1'b1;
        send_frame(1, 0, 32'hC0A80108, 16'h0, 1'b0, 1'b0);
        send_frame(1, 20, 32'hC0A80109, 16'h0, 1'b0, 1'b0);
        wait_idle(4000, "throttle");
        throttle = 1'b0;
        chk("throttle_frame_cnt", 64'(frame_cnt), 64'd9);

        // Asynchronous reset mid-payload
        send_frame(0, 10, 32'hC0A8010B, 16'h0, 1'b0, 1'b0);
        target = nbytes + 42 + 4;
        n = 0;
        while (n < 500 && nbytes < target) begin
            @(posedge clk);
            n++;
        end
        chk("reset_reach_payload", 64'(nbytes >= target), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("arst_tx_eof", 64'(bus.tx_eof), 64'd0);
        chk("arst_rx_ready", 64'(bus.rx_ready), 64'd0);
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        for (int c = 0; c < CH; c++) src_q[c].delete();
        tb_id = IDI;
        tb_frames = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        send_frame(2, 4, 32'hC0A80114, 16'h0, 1'b0, 1'b0);
        wait_idle(2000, "post_reset");
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("post_reset_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
